// File: rtl/multi_edge_det.sv
// Multi-channel synchronising, debouncing edge detector with masked events,
// sticky per-channel flags and a saturating total-event counter.
module multi_edge_det #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] flag_clr,
   output logic [WIDTH-1:0] pe,
   output logic [WIDTH-1:0] ne,
   output logic [WIDTH-1:0] ev,
   output logic [WIDTH-1:0] flag,
   output logic [CNT_W-1:0] ev_cnt,
   output logic             any_ev
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE) + 1;
   localparam int unsigned DB_LAST = (DEBOUNCE > 1) ? DEBOUNCE - 1 : 0;
   localparam int unsigned PC_W    = $clog2(WIDTH + 1);
   localparam int unsigned SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DB_W-1:0]  db_cnt [WIDTH];
   logic [DB_W-1:0]  db_cnt_next [WIDTH];
   logic [WIDTH-1:0] syn;
   logic [WIDTH-1:0] st;
   logic [WIDTH-1:0] st_next;
   logic [PC_W-1:0]  ev_pop;
   logic [SUM_W-1:0] cnt_sum;
   logic [CNT_W-1:0] ev_cnt_next;

   assign syn = sync_q[SYNC_STAGES-1];

   // Input synchroniser chain, one column per channel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= sig;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Filtered state flips only after DEBOUNCE consecutive differing cycles
   always_comb begin
      st_next = st;
      for (int i = 0; i < WIDTH; i++) begin
         db_cnt_next[i] = '0;
         if (syn[i] != st[i]) begin
            if (db_cnt[i] == DB_W'(DB_LAST)) st_next[i] = syn[i];
            else                             db_cnt_next[i] = db_cnt[i] + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= '0;
         pe <= '0;
         ne <= '0;
         for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
      end else begin
         st <= st_next;
         pe <= st_next & ~st;
         ne <= ~st_next & st;
         for (int i = 0; i < WIDTH; i++) db_cnt[i] <= db_cnt_next[i];
      end
   end

   assign ev     = (pe & rise_en) | (ne & fall_en);
   assign any_ev = |ev;

   // Saturating add of this cycle's event population
   always_comb begin
      ev_pop = '0;
      for (int i = 0; i < WIDTH; i++) ev_pop = ev_pop + PC_W'(ev[i]);
      cnt_sum = SUM_W'(ev_cnt) + SUM_W'(ev_pop);
      if (cnt_sum > SUM_W'(CNT_MAX)) ev_cnt_next = CNT_MAX;
      else                           ev_cnt_next = CNT_W'(cnt_sum);
   end

   // Set dominates clear when both land in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag   <= '0;
         ev_cnt <= '0;
      end else begin
         flag   <= ev | (flag & ~flag_clr);
         ev_cnt <= ev_cnt_next;
      end
   end

endmodule

// File: tb/tb_multi_edge_det.sv
// Directed bench for multi_edge_det: DEBOUNCE=3 main instance plus a
// DEBOUNCE=0 instance for the unfiltered path.
module tb_multi_edge_det;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sig, sig0, rise_en, fall_en, flag_clr;
   logic [3:0] pe, ne, ev, flag, ev_cnt;
   logic       any_ev;
   logic [3:0] pe0, ne0, ev0, flag0, ev_cnt0;
   logic       any_ev0;

   int n_cmp = 0;
   int n_err = 0;
   int pe_n [4];
   int ne_n [4];
   int ev2_n, ev2_bad;
   int s_pe [4];
   int s_ne [4];
   int s_ev2, s_ev2_bad;

   always #5 clk = ~clk;

   multi_edge_det #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(3), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .sig(sig), .rise_en(rise_en), .fall_en(fall_en),
      .flag_clr(flag_clr), .pe(pe), .ne(ne), .ev(ev), .flag(flag),
      .ev_cnt(ev_cnt), .any_ev(any_ev));

   multi_edge_det #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .sig(sig0), .rise_en(rise_en), .fall_en(fall_en),
      .flag_clr(flag_clr), .pe(pe0), .ne(ne0), .ev(ev0), .flag(flag0),
      .ev_cnt(ev_cnt0), .any_ev(any_ev0));

   // Pulse counters on the main instance
   always @(posedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (pe[c]) pe_n[c] <= pe_n[c] + 1;
         if (ne[c]) ne_n[c] <= ne_n[c] + 1;
      end
      if (ev[2]) ev2_n <= ev2_n + 1;
      if (ev[2] && !ne[2]) ev2_bad <= ev2_bad + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      for (int c = 0; c < 4; c++) begin
         s_pe[c] = pe_n[c];
         s_ne[c] = ne_n[c];
      end
      s_ev2     = ev2_n;
      s_ev2_bad = ev2_bad;
   endtask

   initial begin
      rst = 1'b1; sig = '0; sig0 = '0; rise_en = '1; fall_en = '1; flag_clr = '0;
      tick(3);
      check_eq("rst_pe", 32'(pe), 0);
      check_eq("rst_ne", 32'(ne), 0);
      check_eq("rst_ev", 32'({any_ev, ev}), 0);
      check_eq("rst_flag", 32'(flag), 0);
      check_eq("rst_cnt", 32'(ev_cnt), 0);
      rst = 1'b0;
      tick(3);

      // Clean rise on channel 0: pulse in the cycle after edge k+4
      sig[0] = 1'b1;
      tick(4);
      check_eq("rise_early", 32'(pe), 0);
      tick();
      check_eq("rise_pe", 32'(pe), 32'h1);
      check_eq("rise_ev", 32'({any_ev, ev}), 32'h11);
      check_eq("rise_flag_lag", 32'(flag), 0);
      tick();
      check_eq("rise_pe_end", 32'(pe), 0);
      check_eq("rise_flag", 32'(flag), 32'h1);
      check_eq("rise_cnt", 32'(ev_cnt), 1);

      // Two-cycle glitch on channel 1 is rejected
      snap();
      sig[1] = 1'b1;
      tick(2);
      sig[1] = 1'b0;
      tick(10);
      check_eq("glitch_pe", 32'(pe_n[1] - s_pe[1]), 0);
      check_eq("glitch_ne", 32'(ne_n[1] - s_ne[1]), 0);
      check_eq("glitch_cnt", 32'(ev_cnt), 1);

      // Three-cycle pulse passes: one rise, then one fall
      snap();
      sig[1] = 1'b1;
      tick(3);
      sig[1] = 1'b0;
      tick(12);
      check_eq("pulse3_pe", 32'(pe_n[1] - s_pe[1]), 1);
      check_eq("pulse3_ne", 32'(ne_n[1] - s_ne[1]), 1);
      check_eq("pulse3_cnt", 32'(ev_cnt), 3);

      // Masking: only the fall on channel 2 counts
      rise_en = 4'b0000; fall_en = 4'b0100;
      snap();
      sig[2] = 1'b1;
      tick(10);
      sig[2] = 1'b0;
      tick(10);
      check_eq("mask_pe", 32'(pe_n[2] - s_pe[2]), 1);
      check_eq("mask_ne", 32'(ne_n[2] - s_ne[2]), 1);
      check_eq("mask_ev", 32'(ev2_n - s_ev2), 1);
      check_eq("mask_ev_only_ne", 32'(ev2_bad - s_ev2_bad), 0);
      check_eq("mask_cnt", 32'(ev_cnt), 4);
      check_eq("mask_flag", 32'(flag), 32'h7);

      // Clear alone for one cycle
      flag_clr = 4'hF;
      tick();
      flag_clr = '0;
      check_eq("clr_alone", 32'(flag), 0);

      // Simultaneous rise on all channels
      rise_en = '1; fall_en = '1;
      sig = '0;
      tick(10);
      check_eq("fall0_cnt", 32'(ev_cnt), 5);
      sig = 4'hF;
      tick(5);
      check_eq("simul_pe", 32'(pe), 32'hF);
      check_eq("simul_ne", 32'(ne), 0);
      tick();
      check_eq("simul_cnt", 32'(ev_cnt), 9);
      check_eq("simul_flag", 32'(flag), 32'hF);
      flag_clr = 4'hF;
      tick();
      flag_clr = '0;
      check_eq("clr_all", 32'(flag), 0);

      // Set wins over a coincident clear on channel 0
      sig[0] = 1'b0;
      tick(5);
      check_eq("race_ne", 32'(ne), 32'h1);
      flag_clr = 4'h1;
      tick();
      check_eq("race_flag", 32'(flag), 32'h1);
      tick();
      check_eq("race_hold_clr", 32'(flag), 0);
      flag_clr = '0;
      check_eq("race_cnt", 32'(ev_cnt), 10);

      // Saturation
      sig = '0;
      tick(8);
      check_eq("sat_pre", 32'(ev_cnt), 13);
      sig = 4'hF;
      tick(8);
      check_eq("sat_hit", 32'(ev_cnt), 15);
      sig = '0;
      tick(8);
      check_eq("sat_hold", 32'(ev_cnt), 15);
      check_eq("sat_flag", 32'(flag), 32'hF);

      // Async reset in the middle of a debounce count
      sig = 4'hF;
      tick(3);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_flag", 32'(flag), 0);
      check_eq("arst_cnt", 32'(ev_cnt), 0);
      check_eq("arst_pe_ne", 32'({pe, ne}), 0);
      check_eq("arst_ev", 32'({any_ev, ev}), 0);
      sig = '0;
      snap();
      tick(2);
      rst = 1'b0;
      tick(10);
      check_eq("arst_no_pe", 32'(pe_n[0] + pe_n[1] + pe_n[2] + pe_n[3]
                                 - s_pe[0] - s_pe[1] - s_pe[2] - s_pe[3]), 0);
      check_eq("arst_no_ne", 32'(ne_n[0] + ne_n[1] + ne_n[2] + ne_n[3]
                                 - s_ne[0] - s_ne[1] - s_ne[2] - s_ne[3]), 0);

      // DEBOUNCE=0: pulse after edge k+2, and a 1-cycle glitch passes
      sig0[0] = 1'b1;
      tick(2);
      check_eq("nodb_early", 32'(pe0), 0);
      tick();
      check_eq("nodb_pe", 32'(pe0), 32'h1);
      tick();
      sig0[1] = 1'b1;
      tick();
      sig0[1] = 1'b0;
      tick(2);
      check_eq("nodb_glitch_pe", 32'({pe0, ne0}), 32'h20);
      tick();
      check_eq("nodb_glitch_ne", 32'({pe0, ne0}), 32'h02);
      tick();
      check_eq("nodb_quiet", 32'({pe0, ne0}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multi_edge_det.md
Name: multi_edge_det

Overview:
- Parametrised, multi-channel successor to the single-bit rising-edge detector.
- Synchronises `WIDTH` asynchronous inputs and debounces each channel.
- Detects rising and falling edges per channel, masked per channel by enables.
- Raises sticky per-channel event flags and keeps a saturating total-event counter; sits between raw pins/status lines and a control/interrupt block.

Parameters:
- WIDTH, 8, number of independent input channels (>=1).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2).
- DEBOUNCE, 4, consecutive cycles a synchronised level must differ from the filtered state before the state flips; 0 and 1 both mean no filtering.
- CNT_W, 8, width of the total event counter (>=1).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig  input  WIDTH  raw asynchronous channel inputs.
- rise_en  input  WIDTH  per-channel enable for rising-edge events (quasi-static).
- fall_en  input  WIDTH  per-channel enable for falling-edge events (quasi-static).
- flag_clr  input  WIDTH  per-channel clear for sticky flags, level-sensitive, sampled each clk.
- pe  output  WIDTH  one-cycle pulse on filtered rising edge, unmasked.
- ne  output  WIDTH  one-cycle pulse on filtered falling edge, unmasked.
- ev  output  WIDTH  masked event, ev = (pe & rise_en) | (ne & fall_en), combinational from registers.
- flag  output  WIDTH  sticky event flags.
- ev_cnt  output  CNT_W  saturating count of all ev pulses since reset.
- any_ev  output  1  OR-reduction of ev.

Behaviour:
- Reset (async, rst=1):
  - All synchroniser flops, filtered state st, debounce counters, pe, ne, flag and ev_cnt go to 0 immediately.
  - ev and any_ev therefore read 0.
  - Reset asserted mid-debounce discards the partial count.
  - After release, a channel whose sig is already 1 produces one pe once it passes sync + debounce. This is intended and means power-up-high lines report a rise.
- Synchroniser: per channel, a chain of SYNC_STAGES flops. Let syn be the last stage.
- Debounce, per channel, with a counter of width clog2(DEBOUNCE)+1:
  - Each cycle where syn != st, the counter increments.
  - When syn != st and the counter == max(DEBOUNCE,1)-1, st <= syn and the counter clears.
  - Any cycle where syn == st clears the counter, so a glitch shorter than DEBOUNCE cycles never reaches st.
- Edge pulses, registered alongside st:
  - pe <= st_next & ~st; ne <= ~st_next & st.
  - Each is high exactly one cycle per flip; pe and ne are never high together on one channel.
- Latency: for a clean level change first captured at edge k, pe/ne are high during the cycle after edge k + SYNC_STAGES + max(DEBOUNCE,1) - 1.
- Channels are fully independent; simultaneous edges on several channels all report in the same cycle.
- Sticky flags, per channel, next flag = ev | (flag & ~flag_clr):
  - Set in the cycle after ev.
  - If ev and flag_clr coincide, set wins (flag stays 1).
  - flag_clr held high keeps flag 0 except in the cycle after an ev.
- Counter:
  - ev_cnt <= min(ev_cnt + popcount(ev), 2^CNT_W - 1) each cycle.
  - Multiple simultaneous events add together.
  - Saturates; it never wraps.
  - Cleared only by rst.
- Enables: changing rise_en/fall_en affects only ev, flag and ev_cnt. It never alters st, pe or ne, and never creates a pulse by itself.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE=3, CNT_W=4 unless noted):
- Reset, clean rise: after reset release with all enables=1, drive sig[0] 0->1 before edge k. Required: pe[0]=1 for exactly the cycle after edge k+4; ev[0], any_ev follow; flag[0]=1 from the next cycle; ev_cnt=1.
- Glitch reject: drive sig[1] high for 2 cycles, then low. Required: no pe/ne on channel 1 and ev_cnt unchanged. Then hold sig[1] high for 3 cycles: exactly one pe[1].
- Masking and falling edge: with rise_en=0000, fall_en=0100, toggle sig[2] 0->1->0 with 10-cycle holds. Required: pe[2] and ne[2] each pulse once; ev[2] pulses only with ne[2]; ev_cnt += 1.
- Simultaneous events and clear race:
  - Raise sig[3:0]=1111 at once. Required: pe=1111 in one cycle and ev_cnt += 4.
  - Assert flag_clr[0]=1 in the same cycle as a later ev[0]. Required: flag[0] remains 1.
  - Assert flag_clr alone for one cycle. Required: flag clears to 0.
- Saturation and async reset:
  - Generate 20 events. Required: ev_cnt stops at 15.
  - Assert rst mid-debounce with no clk edge. Required: all outputs 0 immediately, with no pe/ne pulse following the discarded partial count.
- DEBOUNCE=0: a single change produces pe after SYNC_STAGES edges (edge k+2). Required: a 1-cycle glitch that survives the synchroniser propagates as a pe/ne pair.
